// File: rtl/fp_pkg.sv
// Shared Q-format definitions for the fixed-point divider and multiplier.
// Carries the default format, the value type and the sign/saturation helpers.
package fp_pkg;

  localparam int FP_WIDTH = 32;
  localparam int FP_FBITS = 24;

  typedef logic signed [FP_WIDTH-1:0] fp_t;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } fp_state_e;

  // Magnitude as unsigned; the most negative value maps to 2^(FP_WIDTH-1).
  function automatic logic [FP_WIDTH-1:0] fp_abs(input fp_t x);
    logic [FP_WIDTH-1:0] u;
    u = x;
    if (u[FP_WIDTH-1]) begin
      return ~u + {{(FP_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      return u;
    end
  endfunction

  function automatic fp_t fp_sat_max();
    return {1'b0, {(FP_WIDTH-1){1'b1}}};
  endfunction

  function automatic fp_t fp_sat_min();
    return {1'b1, {(FP_WIDTH-1){1'b0}}};
  endfunction

endpackage

// File: rtl/fp_mul_if.sv
// Handshake and operand/result bundle of the fixed-point multiplier.
// The requester uses the master view, the multiplier the slave view.
interface fp_mul_if
  import fp_pkg::*;
#(
  parameter int WIDTH = FP_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             valid;
  logic             ovf;
  logic [WIDTH-1:0] p;

  modport master (
    output start, a, b,
    input  busy, valid, ovf, p
  );

  modport slave (
    input  start, a, b,
    output busy, valid, ovf, p
  );

endinterface

// File: rtl/fp_mul.sv
// Iterative signed Q-format multiplier: shift-add on magnitudes, one multiplier
// bit per cycle, sign and range handling applied on the final iteration.
module fp_mul
  import fp_pkg::*;
#(
  parameter int WIDTH = FP_WIDTH,
  parameter int FBITS = FP_FBITS,
  parameter int SAT   = 0
) (
  input  logic     clk,
  input  logic     rst,
  fp_mul_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]      CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]      CNT_LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0]   W_ONE    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0] POS_LIM  = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic [2*WIDTH-1:0] NEG_LIM  = {{WIDTH{1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};

  fp_state_e          state_q, state_d;
  logic               busy_q, busy_d;
  logic               valid_q, valid_d;
  logic               ovf_q, ovf_d;
  logic [WIDTH-1:0]   p_q, p_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic               neg_q, neg_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;

  logic [WIDTH:0]     sum_s;
  logic [2*WIDTH-1:0] acc_next_s;
  logic [2*WIDTH-1:0] mag_s;
  logic [WIDTH-1:0]   mag_lo_s;
  logic               ovf_s;
  logic [WIDTH-1:0]   res_s;

  // The multiplier magnitude sits in the low half of the accumulator, so the
  // bit tested each cycle is acc_q[0] and it is shifted out as the product grows.
  always_comb begin
    sum_s      = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
               + {1'b0, (acc_q[0] ? mcand_q : {WIDTH{1'b0}})};
    acc_next_s = {sum_s, acc_q[WIDTH-1:1]};
    mag_s      = acc_next_s >> FBITS;
    mag_lo_s   = mag_s[WIDTH-1:0];
    ovf_s      = neg_q ? (mag_s > NEG_LIM) : (mag_s > POS_LIM);
    if (ovf_s) begin
      if (SAT != 0) begin
        res_s = neg_q ? fp_sat_min() : fp_sat_max();
      end else begin
        res_s = {WIDTH{1'b0}};
      end
    end else begin
      res_s = neg_q ? (~mag_lo_s + W_ONE) : mag_lo_s;
    end
  end

  // Next-state: start restarts from any state, otherwise iterate while running.
  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    mcand_d = mcand_q;
    neg_d   = neg_q;
    acc_d   = acc_q;
    if (bus.start) begin
      state_d = ST_RUN;
      busy_d  = 1'b1;
      valid_d = 1'b0;
      ovf_d   = 1'b0;
      cnt_d   = {CW{1'b0}};
      mcand_d = fp_abs(bus.a);
      neg_d   = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
      acc_d   = {{WIDTH{1'b0}}, fp_abs(bus.b)};
    end else begin
      case (state_q)
        ST_IDLE: begin
          busy_d = 1'b0;
        end
        ST_RUN: begin
          acc_d = acc_next_s;
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_q == CNT_LAST) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            valid_d = 1'b1;
            ovf_d   = ovf_s;
            p_d     = res_s;
          end else begin
            busy_d  = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      p_q     <= {WIDTH{1'b0}};
      cnt_q   <= {CW{1'b0}};
      mcand_q <= {WIDTH{1'b0}};
      neg_q   <= 1'b0;
      acc_q   <= {(2*WIDTH){1'b0}};
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
      mcand_q <= mcand_d;
      neg_q   <= neg_d;
      acc_q   <= acc_d;
    end
  end

  assign bus.busy  = busy_q;
  assign bus.valid = valid_q;
  assign bus.ovf   = ovf_q;
  assign bus.p     = p_q;

endmodule

// File: tb/tb_fp_mul.sv
// Directed bench for fp_mul: a wrap-to-zero and a saturating instance share
// stimulus; every expected product is a hand-computed Q8.24 constant.
module tb_fp_mul;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  fp_mul_if #(.WIDTH(32)) if0 ();
  fp_mul_if #(.WIDTH(32)) if1 ();

  fp_mul #(.WIDTH(32), .FBITS(24), .SAT(0)) u_dut0 (.clk(clk), .rst(rst), .bus(if0));
  fp_mul #(.WIDTH(32), .FBITS(24), .SAT(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));

  always #5 clk = ~clk;

  task automatic pulse_start(input logic [31:0] av, input logic [31:0] bv);
    @(posedge clk);
    #1;
    if0.a = av; if0.b = bv; if0.start = 1'b1;
    if1.a = av; if1.b = bv; if1.start = 1'b1;
    @(posedge clk);
    #1;
    if0.start = 1'b0;
    if1.start = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (if0.valid === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (if0.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", if0.busy); else n_pass++;
    n_checks++; if (if0.valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", if0.valid); else n_pass++;
    n_checks++; if (if0.ovf !== 1'b0) $display("FAIL reset_ovf: got %b want 0", if0.ovf); else n_pass++;
    n_checks++; if (if0.p !== 32'h0000_0000) $display("FAIL reset_p: got %h want 00000000", if0.p); else n_pass++;
    n_checks++; if (if1.valid !== 1'b0) $display("FAIL reset_valid_sat: got %b want 0", if1.valid); else n_pass++;
    n_checks++; if (if1.p !== 32'h0000_0000) $display("FAIL reset_p_sat: got %h want 00000000", if1.p); else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic busy_drop;
    busy_drop = 1'b0;
    pulse_start(32'h0180_0000, 32'h0200_0000);
    n_checks++; if (if0.busy !== 1'b1) $display("FAIL basic_busy_e0: got %b want 1", if0.busy); else n_pass++;
    for (int k = 1; k <= 31; k++) begin
      @(posedge clk);
      #1;
      if (if0.busy !== 1'b1 || if0.valid !== 1'b0) busy_drop = 1'b1;
    end
    n_checks++; if (busy_drop !== 1'b0) $display("FAIL basic_run_window: got early end %b want 0", busy_drop); else n_pass++;
    @(posedge clk);
    #1;
    n_checks++; if (if0.valid !== 1'b1) $display("FAIL basic_valid_e32: got %b want 1", if0.valid); else n_pass++;
    n_checks++; if (if0.busy !== 1'b0) $display("FAIL basic_busy_e32: got %b want 0", if0.busy); else n_pass++;
    n_checks++; if (if0.p !== 32'h0300_0000) $display("FAIL basic_p: got %h want 03000000", if0.p); else n_pass++;
    n_checks++; if (if0.ovf !== 1'b0) $display("FAIL basic_ovf: got %b want 0", if0.ovf); else n_pass++;
  endtask

  task automatic test_signs();
    int lat;
    pulse_start(32'hFE80_0000, 32'h0200_0000);
    wait_valid(lat);
    n_checks++; if (lat !== 32) $display("FAIL signs_neg_latency: got %0d want 32", lat); else n_pass++;
    n_checks++; if (if0.p !== 32'hFD00_0000) $display("FAIL signs_neg_p: got %h want fd000000", if0.p); else n_pass++;
    n_checks++; if (if0.ovf !== 1'b0) $display("FAIL signs_neg_ovf: got %b want 0", if0.ovf); else n_pass++;
    pulse_start(32'hFE80_0000, 32'hFE00_0000);
    wait_valid(lat);
    n_checks++; if (if0.p !== 32'h0300_0000) $display("FAIL signs_negneg_p: got %h want 03000000", if0.p); else n_pass++;
    n_checks++; if (if0.ovf !== 1'b0) $display("FAIL signs_negneg_ovf: got %b want 0", if0.ovf); else n_pass++;
    pulse_start(32'h0000_0000, 32'h8765_4321);
    wait_valid(lat);
    n_checks++; if (if0.p !== 32'h0000_0000) $display("FAIL signs_zero_p: got %h want 00000000", if0.p); else n_pass++;
    n_checks++; if (if0.ovf !== 1'b0) $display("FAIL signs_zero_ovf: got %b want 0", if0.ovf); else n_pass++;
  endtask

  task automatic test_truncation();
    int lat;
    pulse_start(32'h0000_0001, 32'h0080_0000);
    wait_valid(lat);
    n_checks++; if (if0.p !== 32'h0000_0000) $display("FAIL trunc_pos_p: got %h want 00000000", if0.p); else n_pass++;
    pulse_start(32'hFFFF_FFFF, 32'h0080_0000);
    wait_valid(lat);
    n_checks++; if (if0.p !== 32'h0000_0000) $display("FAIL trunc_neg_p: got %h want 00000000", if0.p); else n_pass++;
    n_checks++; if (if0.ovf !== 1'b0) $display("FAIL trunc_neg_ovf: got %b want 0", if0.ovf); else n_pass++;
    pulse_start(32'hFFFF_FFFF, 32'h0300_0000);
    wait_valid(lat);
    n_checks++; if (if0.p !== 32'hFFFF_FFFD) $display("FAIL trunc_neg_small_p: got %h want fffffffd", if0.p); else n_pass++;
  endtask

  task automatic test_overflow();
    int lat;
    pulse_start(32'h4000_0000, 32'h0400_0000);
    wait_valid(lat);
    n_checks++; if (if0.ovf !== 1'b1) $display("FAIL ovf_pos_flag: got %b want 1", if0.ovf); else n_pass++;
    n_checks++; if (if0.p !== 32'h0000_0000) $display("FAIL ovf_pos_p_zero: got %h want 00000000", if0.p); else n_pass++;
    n_checks++; if (if1.ovf !== 1'b1) $display("FAIL ovf_pos_flag_sat: got %b want 1", if1.ovf); else n_pass++;
    n_checks++; if (if1.p !== 32'h7FFF_FFFF) $display("FAIL ovf_pos_p_sat: got %h want 7fffffff", if1.p); else n_pass++;
    pulse_start(32'hC000_0000, 32'h0400_0000);
    wait_valid(lat);
    n_checks++; if (if0.p !== 32'h0000_0000) $display("FAIL ovf_neg_p_zero: got %h want 00000000", if0.p); else n_pass++;
    n_checks++; if (if1.p !== 32'h8000_0000) $display("FAIL ovf_neg_p_sat: got %h want 80000000", if1.p); else n_pass++;
    n_checks++; if (if1.ovf !== 1'b1) $display("FAIL ovf_neg_flag_sat: got %b want 1", if1.ovf); else n_pass++;
  endtask

  task automatic test_boundary();
    int lat;
    pulse_start(32'hF800_0000, 32'h1000_0000);
    wait_valid(lat);
    n_checks++; if (if0.p !== 32'h8000_0000) $display("FAIL bound_neg_p: got %h want 80000000", if0.p); else n_pass++;
    n_checks++; if (if0.ovf !== 1'b0) $display("FAIL bound_neg_ovf: got %b want 0", if0.ovf); else n_pass++;
    n_checks++; if (if1.ovf !== 1'b0) $display("FAIL bound_neg_ovf_sat: got %b want 0", if1.ovf); else n_pass++;
    pulse_start(32'h0800_0000, 32'h1000_0000);
    wait_valid(lat);
    n_checks++; if (if0.ovf !== 1'b1) $display("FAIL bound_pos_ovf: got %b want 1", if0.ovf); else n_pass++;
    n_checks++; if (if0.p !== 32'h0000_0000) $display("FAIL bound_pos_p: got %h want 00000000", if0.p); else n_pass++;
    n_checks++; if (if1.p !== 32'h7FFF_FFFF) $display("FAIL bound_pos_p_sat: got %h want 7fffffff", if1.p); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int   lat;
    logic seen;
    seen = 1'b0;
    pulse_start(32'h0180_0000, 32'h0200_0000);
    n_checks++; if (if0.valid !== 1'b0) $display("FAIL b2b_valid_cleared: got %b want 0", if0.valid); else n_pass++;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk);
      #1;
      if (if0.valid !== 1'b0) seen = 1'b1;
    end
    pulse_start(32'hFE80_0000, 32'h0200_0000);
    n_checks++; if (seen !== 1'b0) $display("FAIL b2b_first_suppressed: got valid seen %b want 0", seen); else n_pass++;
    wait_valid(lat);
    n_checks++; if (lat !== 32) $display("FAIL b2b_latency: got %0d want 32", lat); else n_pass++;
    n_checks++; if (if0.p !== 32'hFD00_0000) $display("FAIL b2b_p: got %h want fd000000", if0.p); else n_pass++;
  endtask

  task automatic test_reset_mid_run();
    logic stray;
    stray = 1'b0;
    pulse_start(32'h0180_0000, 32'h0200_0000);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_checks++; if (if0.busy !== 1'b0) $display("FAIL rst_mid_busy: got %b want 0", if0.busy); else n_pass++;
    n_checks++; if (if0.valid !== 1'b0) $display("FAIL rst_mid_valid: got %b want 0", if0.valid); else n_pass++;
    n_checks++; if (if0.p !== 32'h0000_0000) $display("FAIL rst_mid_p: got %h want 00000000", if0.p); else n_pass++;
    rst = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (if0.valid !== 1'b0 || if0.busy !== 1'b0) stray = 1'b1;
    end
    n_checks++; if (stray !== 1'b0) $display("FAIL rst_mid_discard: got activity %b want 0", stray); else n_pass++;
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    n_checks = 0;
    n_pass = 0;
    if0.start = 1'b0; if0.a = 32'h0; if0.b = 32'h0;
    if1.start = 1'b0; if1.a = 32'h0; if1.b = 32'h0;
    test_reset();
    test_basic();
    test_signs();
    test_truncation();
    test_overflow();
    test_boundary();
    test_back_to_back();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
